// File: rtl/spi_frame_master.sv
// SPI mode-0 master that streams words from a register bank out on MOSI and writes captured frames back.
// Build option: define SPI_LOOPBACK_EN to sample the registered MOSI instead of the MISO pin.
module spi_frame_master #(
   parameter int unsigned   N       = 8,
   parameter int unsigned   FRAME   = 8,
   parameter int unsigned   DIV     = 4,
   parameter logic [N-1:0]  RX_BASE = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          send,
   input  logic [N-1:0]  n_tx,
   input  logic [31:0]   rd_data,
   output logic [N-1:0]  rd_addr,
   output logic          wr_en,
   output logic [N-1:0]  wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  words_done,
   output logic          sclk,
   output logic          mosi,
   input  logic          miso,
   output logic          cs_n
);

   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned EW = $clog2(2 * FRAME);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(2 * FRAME - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, STORE, DONE} state_t;

   state_t            state;
   logic [N-1:0]      n_last;
   logic [FRAME-1:0]  tx;
   logic [FRAME-1:0]  rx;
   logic [FRAME-1:0]  tx_shl;
   logic [FRAME-1:0]  rx_shl;
   logic [DW-1:0]     div_cnt;
   logic [EW-1:0]     edge_cnt;
   logic              rx_bit;
   logic              unused_bits;

`ifdef SPI_LOOPBACK_EN
   assign rx_bit      = mosi;
   assign unused_bits = ^{rd_data, miso};
`else
   assign rx_bit      = miso;
   assign unused_bits = ^rd_data;
`endif

   assign tx_shl = tx << 1;
   assign rx_shl = (rx << 1) | FRAME'(rx_bit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         n_last     <= '0;
         tx         <= '0;
         rx         <= '0;
         div_cnt    <= '0;
         edge_cnt   <= '0;
         rd_addr    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         words_done <= '0;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (send) begin
                  n_last     <= n_tx;
                  rd_addr    <= '0;
                  words_done <= '0;
                  busy       <= 1'b1;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               tx    <= rd_data[FRAME-1:0];
               state <= SETUP;
            end
            SETUP: begin
               cs_n     <= 1'b0;
               mosi     <= tx[FRAME-1];
               div_cnt  <= '0;
               edge_cnt <= '0;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  sclk    <= ~sclk;
                  // sclk still low here means this toggle is a rising edge
                  if (!sclk) begin
                     rx <= rx_shl;
                  end else begin
                     tx   <= tx_shl;
                     mosi <= tx_shl[FRAME-1];
                  end
                  if (edge_cnt == EDGE_LAST) state <= STORE;
                  else                       edge_cnt <= edge_cnt + 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            STORE: begin
               wr_en      <= 1'b1;
               wr_addr    <= rd_addr + RX_BASE;
               wr_data    <= 32'(rx);
               words_done <= words_done + 1'b1;
               if (rd_addr == n_last) begin
                  state <= DONE;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
                  state   <= LOAD;
               end
            end
            DONE: begin
               cs_n  <= 1'b1;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomized self-checking bench for spi_frame_master against a transaction-level reference model.
module tb_spi_frame_master;

   localparam int unsigned FRAME    = 8;
   localparam int unsigned DIV      = 4;
   localparam int unsigned WORD_CYC = 3 + 2 * FRAME * DIV;
   localparam int unsigned WF       = 5;
   localparam int unsigned WDIV     = 1;
   localparam int unsigned WWORD    = 3 + 2 * WF * WDIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        send = 1'b0;
   logic [7:0]  n_tx = '0;
   logic [31:0] rd_data;
   logic [7:0]  rd_addr;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [7:0]  words_done;
   logic        sclk;
   logic        mosi;
   logic        miso = 1'b0;
   logic        cs_n;

   logic        w_send = 1'b0;
   logic [7:0]  w_n_tx = '0;
   logic [31:0] w_rd_data;
   logic [7:0]  w_rd_addr;
   logic        w_wr_en;
   logic [7:0]  w_wr_addr;
   logic [31:0] w_wr_data;
   logic        w_busy;
   logic        w_done;
   logic [7:0]  w_words_done;
   logic        w_sclk;
   logic        w_mosi;
   logic        w_cs_n;

   logic [31:0] bank [256];
   logic [7:0]  rxw  [16];

   int unsigned total = 0;
   int unsigned bad   = 0;

   assign rd_data   = bank[rd_addr];
   assign w_rd_data = bank[w_rd_addr];

   spi_frame_master #(.N(8), .FRAME(FRAME), .DIV(DIV), .RX_BASE(8'h00)) dut (
      .clk(clk), .rst(rst), .send(send), .n_tx(n_tx), .rd_data(rd_data), .rd_addr(rd_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
      .words_done(words_done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   spi_frame_master #(.N(8), .FRAME(WF), .DIV(WDIV), .RX_BASE(8'hFE)) dut_w (
      .clk(clk), .rst(rst), .send(w_send), .n_tx(w_n_tx), .rd_data(w_rd_data), .rd_addr(w_rd_addr),
      .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .busy(w_busy), .done(w_done),
      .words_done(w_words_done), .sclk(w_sclk), .mosi(w_mosi), .miso(1'b1), .cs_n(w_cs_n)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Line-side monitor, sampled on the falling clk edge
   logic        sclk_prev = 1'b0;
   int unsigned rise_cnt = 0, busy_cyc = 0, csl_cyc = 0, done_cnt = 0, done_at = 0;
   int unsigned w_done_cnt = 0, w_done_at = 0;
   logic [7:0]  wa_q [$];
   logic [31:0] wd_q [$];
   logic        mosi_q [$];
   logic [7:0]  wwa_q [$];
   logic [31:0] wwd_q [$];

   always @(negedge clk) begin
      if (sclk === 1'b1 && sclk_prev === 1'b0) begin
         rise_cnt++;
         mosi_q.push_back(mosi);
      end
      sclk_prev = sclk;
      if (busy === 1'b1) busy_cyc++;
      if (cs_n === 1'b0) csl_cyc++;
      if (done === 1'b1) begin
         done_cnt++;
         done_at = cyc;
      end
      if (wr_en === 1'b1) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (w_done === 1'b1) begin
         w_done_cnt++;
         w_done_at = cyc;
      end
      if (w_wr_en === 1'b1) begin
         wwa_q.push_back(w_wr_addr);
         wwd_q.push_back(w_wr_data);
      end
   end

   // SPI slave model: presents the next MISO bit after every falling sclk edge
   logic miso_bits [$];
   always @(negedge sclk) miso = (miso_bits.size() > 0) ? miso_bits.pop_front() : 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic load_miso(input int unsigned n);
      miso_bits.delete();
      for (int unsigned i = 0; i <= n; i++)
         for (int k = FRAME - 1; k >= 0; k--)
            miso_bits.push_back(rxw[i][k]);
      miso = miso_bits.pop_front();
   endtask

   task automatic drain;
      wa_q.delete();
      wd_q.delete();
      mosi_q.delete();
   endtask

   // Runs one transfer of n+1 words from bank[0..n]; expected line activity is derived from
   // the bank contents, the MISO words and the per-word cycle cost.
   task automatic run_xfer(input int unsigned n, input bit intrude);
      int unsigned b_busy, b_csl, b_done, t0, waited, nw;
      logic [7:0]  exp_d, got_w;
      load_miso(n);
      drain();
      b_busy = busy_cyc;
      b_csl  = csl_cyc;
      b_done = done_cnt;
      @(negedge clk);
      n_tx = 8'(n);
      send = 1'b1;
      @(negedge clk);
      t0   = cyc;
      send = 1'b0;
      n_tx = 8'($urandom);
      if (intrude) begin
         repeat (20) @(negedge clk);
         n_tx = 8'd5;
         send = 1'b1;
         @(negedge clk);
         send = 1'b0;
      end
      waited = 0;
      while (done_cnt == b_done && waited < (n + 1) * WORD_CYC + 40) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check("done_seen", 32'(done_cnt != b_done), 32'd1);
      repeat (12) @(negedge clk);
      #1;
      check("done_latency", done_at - t0, (n + 1) * WORD_CYC + 1);
      check("done_count", done_cnt - b_done, 32'd1);
      check("busy_cycles", busy_cyc - b_busy, (n + 1) * WORD_CYC + 1);
      check("csn_low_cycles", csl_cyc - b_csl, (n + 1) * WORD_CYC - 1);
      check("busy_idle", 32'(busy), 32'd0);
      check("words_done", 32'(words_done), 32'(n + 1));
      check("wr_count", wa_q.size(), n + 1);
      check("mosi_bits", mosi_q.size(), (n + 1) * FRAME);
      nw = (wa_q.size() < n + 1) ? wa_q.size() : n + 1;
      for (int unsigned i = 0; i < nw; i++) begin
`ifdef SPI_LOOPBACK_EN
         exp_d = bank[i][7:0];
`else
         exp_d = rxw[i];
`endif
         check("wr_addr", 32'(wa_q.pop_front()), i);
         check("wr_data", wd_q.pop_front(), 32'(exp_d));
      end
      for (int unsigned i = 0; i <= n && mosi_q.size() >= FRAME; i++) begin
         got_w = '0;
         for (int unsigned k = 0; k < FRAME; k++) got_w = {got_w[6:0], mosi_q.pop_front()};
         check("mosi_frame", 32'(got_w), 32'(bank[i][7:0]));
      end
   endtask

   initial begin
      int unsigned waited, b_rise, n;
      for (int i = 0; i < 256; i++) bank[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_words_done", 32'(words_done), 32'd0);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      rst = 1'b0;

      // upper rd_data bits must not reach the line
      bank[0] = 32'hFFFF_FFA5;
      rxw[0]  = 8'h3C;
      run_xfer(0, 1'b0);

      bank[0] = 32'h11;
      bank[1] = 32'h22;
      bank[2] = 32'h33;
      for (int i = 0; i < 3; i++) rxw[i] = 8'($urandom);
      run_xfer(2, 1'b0);

      for (int i = 0; i < 2; i++) begin
         bank[i] = $urandom();
         rxw[i]  = 8'($urandom);
      end
      run_xfer(1, 1'b1);

      // reset on the 4th rising sclk edge of a transfer
      bank[0] = $urandom();
      bank[1] = $urandom();
      rxw[0]  = 8'($urandom);
      rxw[1]  = 8'($urandom);
      load_miso(1);
      drain();
      b_rise = rise_cnt;
      @(negedge clk);
      n_tx = 8'd1;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      waited = 0;
      while (rise_cnt - b_rise < 4 && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check("abort_rise_seen", rise_cnt - b_rise, 32'd4);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("abort_cs_n", 32'(cs_n), 32'd1);
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("abort_no_write", wa_q.size(), 32'd0);
      run_xfer(0, 1'b0);

      // second instance: RX_BASE wraps the write address
      for (int i = 0; i < 3; i++) bank[i] = $urandom();
      wwa_q.delete();
      wwd_q.delete();
      @(negedge clk);
      w_n_tx = 8'd2;
      w_send = 1'b1;
      @(negedge clk);
      w_send = 1'b0;
      begin
         int unsigned t0w, bd;
         t0w = cyc;
         bd  = w_done_cnt;
         waited = 0;
         while (w_done_cnt == bd && waited < 3 * WWORD + 20) begin
            @(negedge clk);
            #1;
            waited++;
         end
         check("wrap_done_latency", w_done_at - t0w, 3 * WWORD + 1);
      end
      check("wrap_wr_count", wwa_q.size(), 32'd3);
      for (int i = 0; i < 3 && wwa_q.size() > 0; i++) begin
         check("wrap_wr_addr", 32'(wwa_q.pop_front()), 32'((8'hFE + i) % 256));
`ifdef SPI_LOOPBACK_EN
         check("wrap_wr_data", wwd_q.pop_front(), 32'(bank[i][WF-1:0]));
`else
         check("wrap_wr_data", wwd_q.pop_front(), 32'h1F);
`endif
      end

      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(0, 3);
         for (int unsigned i = 0; i <= n; i++) begin
            bank[i] = $urandom();
            rxw[i]  = 8'($urandom);
         end
         run_xfer(n, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
